// File: rtl/sccb_init_pkg.sv
// Shared definitions for the SCCB register-initialisation sequencer.
//   - ROM entry opcodes (bits [17:16] of an entry)
//   - i2c_module register selects driven on bus_addr
//   - sequencer FSM state type
package sccb_init_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_SLAVE = 3'd1;
  localparam logic [2:0] REG_ADDR  = 3'd2;
  localparam logic [2:0] REG_DATA  = 3'd3;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StWSlv,
    StWReg,
    StWDat,
    StWGo,
    StWaitBusy,
    StWaitDone,
    StDelay,
    StNext,
    StDone,
    StFail
  } state_e;

endpackage

// File: rtl/sccb_init_seq_if.sv
// Register port of the i2c_module master.
//   bus_addr    : register select (ctrl / slave / reg / data)
//   bus_wdata   : register write data
//   bus_write   : one-cycle write strobe
//   bus_ready   : master idle
//   bus_success : last transfer ACKed, valid when bus_ready rises
// master modport: the sequencer; slave modport: the i2c master.
interface sccb_init_seq_if;
  logic [2:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_write;
  logic       bus_ready;
  logic       bus_success;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_write,
    input  bus_ready,
    input  bus_success
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_write,
    output bus_ready,
    output bus_success
  );
endinterface

// File: rtl/sccb_init_delay.sv
// Loadable delay timer: counts count*DELAY_UNIT cycles of 'run'.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture count and restart the prescaler
//   count      : number of DELAY_UNIT periods
//   run        : advance the timer (sequencer is in its delay state)
//   done       : high in the last cycle of the delay
module sccb_init_delay #(
  parameter int unsigned DELAY_UNIT = 50000,
  localparam int unsigned PRE_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] count,
  input  logic        run,
  output logic        done
);

  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(DELAY_UNIT - 1);

  logic [15:0]      cnt_q;
  logic [PRE_W-1:0] pre_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pre_q <= '0;
    end else if (load) begin
      cnt_q <= count;
      pre_q <= PRE_TOP;
    end else if (run && (cnt_q != '0)) begin
      // Stops at zero rather than wrapping if run is held past the end.
      if (pre_q == '0) begin
        pre_q <= PRE_TOP;
        cnt_q <= cnt_q - 16'd1;
      end else begin
        pre_q <= pre_q - 1'b1;
      end
    end
  end

  assign done = run && (cnt_q == 16'd1) && (pre_q == '0);

endmodule

// File: rtl/sccb_init_seq.sv
// Table-driven SCCB/I2C register-initialisation sequencer.
// Fetches {op, reg, val} entries from an external synchronous ROM and executes
// WRITE / DELAY / END (op 11 is a NOP) through the i2c_module register port, with
// bounded retry on NAK and multi-pass looping from LOOP_START.
//   clk, reset : clock, asynchronous active-high reset
//   start      : restart pulse, honoured in IDLE, DONE and FAIL only
//   rom_addr   : ROM index; rom_data valid one cycle later
//   bus        : i2c_module register port (master modport)
//   busy       : run in progress
//   ready      : run completed
//   error      : retry limit reached
// Build option SCCB_INIT_STATUS_EN adds err_index, retry_total and pass_cnt.
module sccb_init_seq
  import sccb_init_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter logic [7:0]  SLAVE_ADDR = 8'h60,
  parameter int unsigned LOOP_START = 3,
  parameter int unsigned PASSES     = 4,
  parameter int unsigned MAX_RETRY  = 7,
  parameter int unsigned DELAY_UNIT = 50000,
  parameter bit          AUTO_START = 1'b1,
  localparam int unsigned IDX_W     = $clog2(DEPTH),
  localparam int unsigned PASS_W    = $clog2(PASSES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [IDX_W-1:0]       rom_addr,
  input  logic [17:0]            rom_data,
  sccb_init_seq_if.master        bus,
  output logic                   busy,
  output logic                   ready,
  output logic                   error
`ifdef SCCB_INIT_STATUS_EN
  ,
  output logic [IDX_W-1:0]       err_index,
  output logic [15:0]            retry_total,
  output logic [PASS_W-1:0]      pass_cnt
`endif
);

  localparam int unsigned RTRY_W = $clog2(MAX_RETRY + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic [17:0]       entry_q, entry_d;
  logic [2:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              busy_q, ready_q, error_q;
  logic              run_start;
  logic              dly_load, dly_run, dly_done;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    retry_d   = retry_q;
    entry_d   = entry_q;
    run_start = 1'b0;
    dly_load  = 1'b0;
    unique case (state_q)
      StIdle:     run_start = start || AUTO_START;
      StFetch:    state_d = StDecode;
      StDecode: begin
        entry_d = rom_data;
        case (rom_data[17:16])
          OP_WRITE: state_d = StWSlv;
          OP_DELAY: begin
            if (rom_data[15:0] != 16'd0) begin
              state_d  = StDelay;
              dly_load = 1'b1;
            end else begin
              state_d = StNext;
            end
          end
          default:  state_d = StNext;
        endcase
      end
      StWSlv:     state_d = StWReg;
      StWReg:     state_d = StWDat;
      StWDat:     state_d = StWGo;
      StWGo:      state_d = StWaitBusy;
      StWaitBusy: if (!bus.bus_ready) state_d = StWaitDone;
      StWaitDone: begin
        if (bus.bus_ready) begin
          if (bus.bus_success) begin
            retry_d = '0;
            state_d = StNext;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == RTRY_W'(MAX_RETRY)) ? StFail : StWSlv;
          end
        end
      end
      StDelay:    if (dly_done) state_d = StNext;
      StNext: begin
        if ((entry_q[17:16] == OP_END) || (idx_q == IDX_W'(DEPTH - 1))) begin
          if (pass_q < PASS_W'(PASSES - 1)) begin
            pass_d  = pass_q + 1'b1;
            idx_d   = IDX_W'(LOOP_START);
            state_d = StFetch;
          end else begin
            state_d = StDone;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone, StFail: run_start = start;
      default:    state_d = StIdle;
    endcase

    if (run_start) begin
      state_d = StFetch;
      idx_d   = '0;
      pass_d  = '0;
      retry_d = '0;
    end
  end

  // Bus outputs are computed from the next state so they are registered yet
  // line up with the strobe states.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    unique case (state_d)
      StWSlv: begin
        write_d = 1'b1;
        addr_d  = REG_SLAVE;
        wdata_d = SLAVE_ADDR;
      end
      StWReg: begin
        write_d = 1'b1;
        addr_d  = REG_ADDR;
        wdata_d = entry_d[15:8];
      end
      StWDat: begin
        write_d = 1'b1;
        addr_d  = REG_DATA;
        wdata_d = entry_d[7:0];
      end
      StWGo: begin
        write_d = 1'b1;
        addr_d  = REG_CTRL;
        wdata_d = 8'h01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pass_q  <= '0;
      retry_q <= '0;
      entry_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      retry_q <= retry_d;
      entry_q <= entry_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      busy_q  <= !(state_d inside {StIdle, StDone, StFail});
      ready_q <= (state_d == StDone);
      error_q <= (state_d == StFail);
    end
  end

  assign dly_run = (state_q == StDelay);

  sccb_init_delay #(
    .DELAY_UNIT(DELAY_UNIT)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .load  (dly_load),
    .count (rom_data[15:0]),
    .run   (dly_run),
    .done  (dly_done)
  );

  assign rom_addr      = idx_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_write = write_q;
  assign busy          = busy_q;
  assign ready         = ready_q;
  assign error         = error_q;

`ifdef SCCB_INIT_STATUS_EN
  logic [IDX_W-1:0] err_index_q;
  logic [15:0]      retry_total_q;
  logic             nak_seen;

  assign nak_seen = (state_q == StWaitDone) && bus.bus_ready && !bus.bus_success;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_index_q   <= '0;
      retry_total_q <= '0;
    end else if (run_start) begin
      err_index_q   <= '0;
      retry_total_q <= '0;
    end else begin
      if (nak_seen && (retry_total_q != 16'hffff)) retry_total_q <= retry_total_q + 16'd1;
      if ((state_d == StFail) && (state_q != StFail)) err_index_q <= idx_q;
    end
  end

  assign err_index   = err_index_q;
  assign retry_total = retry_total_q;
  assign pass_cnt    = pass_q;
`endif

endmodule

// File: tb/tb_sccb_init_seq.sv
// Self-checking bench for sccb_init_seq: a ROM array, a behavioural i2c master
// with configurable NAKs, and a scoreboard of expected register-port strobes.
module tb_sccb_init_seq;
  import sccb_init_pkg::*;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned LOOP_START = 1;
  localparam int unsigned PASSES     = 3;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int unsigned DELAY_UNIT = 10;
  localparam logic [7:0]  SLAVE      = 8'h60;
  localparam int          BOUND      = 2000;
  localparam logic [17:0] ENTRY_END  = {OP_END, 16'h0000};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  rom_addr;
  logic [17:0] rom_data;
  logic        busy, ready, error;
  logic [17:0] rom [DEPTH];

  sccb_init_seq_if bus ();

`ifdef SCCB_INIT_STATUS_EN
  logic [2:0]  err_index;
  logic [15:0] retry_total;
  logic [1:0]  pass_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_got, mon_exp;
  logic [7:0]  nak_reg = 8'h00;
  int          nak_limit = 0;

  always #5 clk = ~clk;

  sccb_init_seq #(
    .DEPTH      (DEPTH),
    .SLAVE_ADDR (SLAVE),
    .LOOP_START (LOOP_START),
    .PASSES     (PASSES),
    .MAX_RETRY  (MAX_RETRY),
    .DELAY_UNIT (DELAY_UNIT),
    .AUTO_START (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .bus      (bus.master),
    .busy     (busy),
    .ready    (ready),
    .error    (error)
`ifdef SCCB_INIT_STATUS_EN
    ,
    .err_index   (err_index),
    .retry_total (retry_total),
    .pass_cnt    (pass_cnt)
`endif
  );

  always @(posedge clk) rom_data <= rom[rom_addr];

  // i2c master model: 3 busy cycles per transfer, NAKs the first nak_limit
  // transfers to nak_reg in each run.
  int         busy_cnt = 0;
  int         naks_given = 0;
  logic [7:0] cur_reg = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bus_ready   <= 1'b1;
      bus.bus_success <= 1'b0;
      busy_cnt   = 0;
      naks_given = 0;
    end else begin
      if (start) naks_given = 0;
      if (bus.bus_write && bus.bus_addr == REG_ADDR) cur_reg <= bus.bus_wdata;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.bus_ready <= 1'b1;
          if (cur_reg == nak_reg && naks_given < nak_limit) begin
            bus.bus_success <= 1'b0;
            naks_given++;
          end else begin
            bus.bus_success <= 1'b1;
          end
        end
      end else if (bus.bus_write && bus.bus_addr == REG_CTRL && bus.bus_wdata == 8'h01) begin
        bus.bus_ready <= 1'b0;
        busy_cnt = 3;
      end
    end
  end

  // Scoreboard consumer: every strobe must match the next expected one.
  always @(negedge clk) begin
    if (!reset && bus.bus_write === 1'b1) begin
      mon_got = {bus.bus_addr, bus.bus_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: got addr/data %h, expected no strobe", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL strobe: got addr/data %h, expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] wr(input logic [7:0] r, input logic [7:0] v);
    return {OP_WRITE, r, v};
  endfunction

  task automatic push_write(input logic [7:0] r, input logic [7:0] v);
    exp_q.push_back({REG_SLAVE, SLAVE});
    exp_q.push_back({REG_ADDR, r});
    exp_q.push_back({REG_DATA, v});
    exp_q.push_back({REG_CTRL, 8'h01});
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = ENTRY_END;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = wr(8'hff, 8'h01);
    rom[1] = wr(8'h12, 8'h80);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, ready, error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/ready/error=%b, expected 000", {busy, ready, error});
    end
    checks++;
    if (rom_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_rom_addr: got %0d, expected 0", rom_addr);
    end
    checks++;
    if ({bus.bus_write, bus.bus_addr, bus.bus_wdata} !== 12'h000) begin
      errors++;
      $display("FAIL reset_bus: write/addr/wdata=%h, expected 000",
               {bus.bus_write, bus.bus_addr, bus.bus_wdata});
    end
`ifdef SCCB_INIT_STATUS_EN
    checks++;
    if ({err_index, retry_total, pass_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL reset_status: got %h, expected 0", {err_index, retry_total, pass_cnt});
    end
`endif
  endtask

  task automatic test_basic();
    bit ok;
    push_write(8'hff, 8'h01);
    for (int p = 0; p < PASSES; p++) push_write(8'h12, 8'h80);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL autostart_busy: got %b, expected 1", busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: busy still %b, expected 0", busy);
    end
    checks++;
    if ({ready, error} !== 2'b10) begin
      errors++;
      $display("FAIL basic_done: ready/error=%b, expected 10", {ready, error});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_left: %0d strobes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_delay();
    bit ok;
    int cnt;
    for (int k = 0; k < 2; k++) begin
      clear_rom();
      rom[0] = {OP_DELAY, 16'(k * 2)};
      rom[1] = wr(8'h34, 8'h56);
      for (int p = 0; p < PASSES; p++) push_write(8'h34, 8'h56);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cnt = 0;
      for (int i = 0; i < BOUND; i++) begin
        @(posedge clk);
        cnt++;
        #1;
        if (bus.bus_write) break;
      end
      checks++;
      if (cnt != 5 + k * 2 * DELAY_UNIT) begin
        errors++;
        $display("FAIL delay_latency: count %0d took %0d cycles, expected %0d",
                 k * 2, cnt, 5 + k * 2 * DELAY_UNIT);
      end
      wait_idle(ok);
      checks++;
      if (!ok || ready !== 1'b1) begin
        errors++;
        $display("FAIL delay_done: ok=%b ready=%b, expected 1 1", ok, ready);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL delay_left: %0d strobes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_retry();
    bit ok;
    clear_rom();
    rom[0] = wr(8'h11, 8'h22);
    rom[1] = wr(8'h33, 8'h44);
    nak_reg   = 8'h33;
    nak_limit = 2;
    push_write(8'h11, 8'h22);
    for (int i = 0; i < 3 + PASSES - 1; i++) push_write(8'h33, 8'h44);
    pulse_start();
    wait_idle(ok);
    checks++;
    if (!ok || {ready, error} !== 2'b10) begin
      errors++;
      $display("FAIL retry_done: ok=%b ready/error=%b, expected 1 10", ok, {ready, error});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL retry_left: %0d strobes outstanding, expected 0", exp_q.size());
    end
`ifdef SCCB_INIT_STATUS_EN
    checks++;
    if (retry_total !== 16'd2) begin
      errors++;
      $display("FAIL retry_total: got %0d, expected 2", retry_total);
    end
    checks++;
    if (pass_cnt !== 2'd2) begin
      errors++;
      $display("FAIL pass_cnt: got %0d, expected 2", pass_cnt);
    end
`endif
  endtask

  task automatic test_fail();
    bit ok;
    nak_reg   = 8'h11;
    nak_limit = 100;
    for (int i = 0; i < MAX_RETRY; i++) push_write(8'h11, 8'h22);
    pulse_start();
    wait_idle(ok);
    checks++;
    if (!ok || {ready, error} !== 2'b01) begin
      errors++;
      $display("FAIL fail_state: ok=%b ready/error=%b, expected 1 01", ok, {ready, error});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fail_left: %0d strobes outstanding, expected 0", exp_q.size());
    end
`ifdef SCCB_INIT_STATUS_EN
    checks++;
    if (err_index !== 3'd0) begin
      errors++;
      $display("FAIL err_index: got %0d, expected 0", err_index);
    end
`endif
    nak_limit = 0;
    push_write(8'h11, 8'h22);
    for (int p = 0; p < PASSES; p++) push_write(8'h33, 8'h44);
    pulse_start();
    wait_idle(ok);
    checks++;
    if (!ok || {ready, error} !== 2'b10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fail_rerun: ok=%b ready/error=%b left=%0d, expected 1 10 0",
               ok, {ready, error}, exp_q.size());
    end
  endtask

  task automatic test_loop();
    bit ok;
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = wr(8'ha0 + 8'(i), 8'(i));
    push_write(8'ha0, 8'h00);
    for (int p = 0; p < PASSES; p++)
      for (int i = 1; i < 4; i++) push_write(8'ha0 + 8'(i), 8'(i));
    pulse_start();
    repeat (20) @(posedge clk);
    // A start pulse mid-run must not restart the table.
    pulse_start();
    wait_idle(ok);
    checks++;
    if (!ok || ready !== 1'b1) begin
      errors++;
      $display("FAIL loop_done: ok=%b ready=%b, expected 1 1", ok, ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL loop_left: %0d strobes outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < DEPTH; i++) rom[i] = wr(8'hb0 + 8'(i), 8'(i));
    for (int i = 0; i < DEPTH; i++) push_write(8'hb0 + 8'(i), 8'(i));
    for (int p = 1; p < PASSES; p++)
      for (int i = LOOP_START; i < DEPTH; i++) push_write(8'hb0 + 8'(i), 8'(i));
    pulse_start();
    wait_idle(ok);
    checks++;
    if (!ok || ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_done: ok=%b ready=%b left=%0d, expected 1 1 0",
               ok, ready, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = wr(8'ha0 + 8'(i), 8'(i));
    push_write(8'ha0, 8'h00);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk);
      #1;
      if (!bus.bus_ready) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_transfer: bus_ready stayed %b, expected 0", bus.bus_ready);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, ready, error, bus.bus_write, bus.bus_addr, bus.bus_wdata, rom_addr} !== 18'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h, expected 0",
               {busy, ready, error, bus.bus_write, bus.bus_addr, bus.bus_wdata, rom_addr});
    end
    exp_q.delete();
    push_write(8'ha0, 8'h00);
    for (int p = 0; p < PASSES; p++)
      for (int i = 1; i < 4; i++) push_write(8'ha0 + 8'(i), 8'(i));
    @(posedge clk);
    #1 reset = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_restart: ok=%b ready=%b left=%0d, expected 1 1 0",
               ok, ready, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_retry();
    test_fail();
    test_loop();
    test_wrap();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_init_seq.md
# sccb_init_seq

Table-driven SCCB/I2C register-initialisation sequencer; parametrised successor to the fixed camera bring-up controller. Fetches 18-bit entries from an external synchronous ROM and executes write, delay and end opcodes. Drives the existing `i2c_module` register port with bounded retry, multi-pass looping and restart-on-demand. Sits between the sensor config ROM and the I2C master, and gates the video pipeline through `ready`.

## Interface
- `DEPTH`, 256: ROM entries; index width `IDX_W = $clog2(DEPTH)`.
- `SLAVE_ADDR`, 8'h60: 8-bit write address of the target.
- `LOOP_START`, 3: index to re-enter on passes 2..`PASSES`.
- `PASSES`, 4: total passes over the table (≥1).
- `MAX_RETRY`, 7: failed transfers per entry before FAIL (≥1).
- `DELAY_UNIT`, 50000: clk cycles per delay count.
- `AUTO_START`, 1: start a run on reset release.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse; restarts the run from DONE/FAIL.
- `rom_addr` out IDX_W: entry index.
- `rom_data` in 18: `{op[1:0], reg[7:0], val[7:0]}`; valid one cycle after `rom_addr`.
- `bus_addr` out 3: master register select (0 ctrl, 1 slave, 2 reg, 3 data).
- `bus_wdata` out 8: master register data.
- `bus_write` out 1: one-cycle master write strobe.
- `bus_ready` in 1: master idle.
- `bus_success` in 1: last transfer was ACKed; sampled when `bus_ready` rises.
- `busy` out 1: run in progress.
- `ready` out 1: run completed successfully.
- `error` out 1: retry limit hit.

## Operation
- Opcodes:
  - 00 WRITE: write reg/val.
  - 01 DELAY: wait `{reg,val}*DELAY_UNIT` cycles; count 0 = no wait.
  - 10 END: end of pass.
  - 11: reserved, treated as NOP.
- States: IDLE, FETCH, DECODE, W_SLV, W_REG, W_DAT, W_GO, WAIT_BUSY, WAIT_DONE, DELAY, NEXT, DONE, FAIL.
- IDLE → FETCH on `start`, or on the first cycle after reset when `AUTO_START`=1. Index, pass and retry counters are cleared.
- FETCH drives `rom_addr`; DECODE registers `rom_data` and dispatches by opcode.
- W_SLV/W_REG/W_DAT/W_GO: one cycle each, each with `bus_write`=1. Data is `SLAVE_ADDR`, reg, val, then 8'h01 to ctrl.
- WAIT_BUSY holds until `bus_ready`=0. WAIT_DONE holds until `bus_ready`=1.
- On `bus_success`=1 in WAIT_DONE: go to NEXT and clear the retry counter.
- On `bus_success`=0: increment the retry counter.
  - If it reaches `MAX_RETRY` → FAIL.
  - Otherwise → W_SLV, re-issuing the same entry.
- NEXT, when the entry was END or index = `DEPTH-1`:
  - If pass < `PASSES-1`: pass++, index ← `LOOP_START`.
  - Otherwise → DONE.
- NEXT otherwise: index++ → FETCH.
- DONE: `ready`=1. FAIL: `error`=1. Both hold until `start`, which re-enters FETCH at index 0 with counters cleared.
- `start` in any other state is ignored.
- `reset` mid-transfer returns to IDLE immediately; the master is reset in parallel by the same net.

## Timing
- Reset values:
  - Outputs: `rom_addr`=0, `bus_addr`=0, `bus_wdata`=0, `bus_write`=0, `busy`=0, `ready`=0, `error`=0.
  - State: IDLE.
- All outputs are registered.
- `busy`=1 in every state except IDLE, DONE and FAIL.
- Per WRITE entry: 2 cycles fetch/decode + 4 strobe cycles + master time + 1 cycle NEXT.
- DELAY entry: exactly `N*DELAY_UNIT` cycles in DELAY, plus 3 overhead cycles.
- The delay counter is `16+$clog2(DELAY_UNIT)` bits and never wraps.
- Retry counter is `$clog2(MAX_RETRY+1)` bits; pass counter is `$clog2(PASSES+1)` bits.
- A `start` pulse in the same cycle as the DONE entry is ignored.

## Configuration
- `SCCB_INIT_STATUS_EN` defined adds three outputs:
  - `err_index` IDX_W: index of the failing entry, held in FAIL.
  - `retry_total` 16: saturating count of all NAKs this run.
  - `pass_cnt`: current pass.
- All three reset to 0.
- Undefined: the ports and counters are absent; core behaviour is identical.

## Structure
- Package `sccb_init_pkg`:
  - Opcode localparams `OP_WRITE`, `OP_DELAY`, `OP_END`.
  - Master register selects `REG_CTRL`, `REG_SLAVE`, `REG_ADDR`, `REG_DATA`.
  - State enum typedef.
- Sub-module `sccb_init_delay`: loadable down-counter with prescaler and `done` pulse; used by the DELAY state.
- The ROM is external; the camera table becomes a separate ROM file.

## Test plan
- Reset, `AUTO_START`=1, 3-entry table {WRITE ff/01, WRITE 12/80, END}, `PASSES`=1, master model always ACKs → two 4-strobe write sequences with data 60,ff,01,01 then 60,12,80,01; `ready`=1; `busy`=0.
- DELAY entry 0x0002 with `DELAY_UNIT`=10 → exactly 20 cycles in DELAY, then the next fetch.
- Master NAKs entry 1 twice then ACKs, `MAX_RETRY`=7 → entry 1 issued 3 times; `ready`=1; `retry_total`=2 when `SCCB_INIT_STATUS_EN` is defined.
- Master always NAKs, `MAX_RETRY`=3 → FAIL after 3 attempts; `error`=1; `err_index`=0. A `start` pulse re-runs from index 0.
- `PASSES`=3, `LOOP_START`=1, 4-entry table → entry 0 written once, entries 1–3 written 3 times, then `ready`.
- Reset asserted during WAIT_DONE → all outputs 0 on the same edge; IDLE; auto-start restarts at index 0.
